// File: rtl/p1p2_arbiter_if.sv
// p1p2_arbiter_if: bundles the requester handshake and the arbiter status
// outputs shared by the two push-button requesters and the arbiter.
//   P1, P2        : level-sensitive requests
//   done1, done2  : release strobes from the current grant holder
//   g1, g2        : one-hot registered grants
//   z             : resource busy (g1|g2)
//   last          : last requester served (0 = P1, 1 = P2)
//   timeout       : one-cycle pulse on a hold-limit forced release
// master = requester side, slave = arbiter side.
interface p1p2_arbiter_if;
  logic P1;
  logic P2;
  logic done1;
  logic done2;
  logic g1;
  logic g2;
  logic z;
  logic last;
  logic timeout;

  modport master (
    output P1, P2, done1, done2,
    input  g1, g2, z, last, timeout
  );

  modport slave (
    input  P1, P2, done1, done2,
    output g1, g2, z, last, timeout
  );
endinterface

// File: rtl/p1p2_arbiter.sv
// p1p2_arbiter: round-robin arbiter sharing one resource between requesters
// P1 and P2. Grants are one-hot and registered, each grant is bounded by a
// hold limit of HOLD_MAX cycles, and every release is followed by GAP dead
// cycles before the arbiter can grant again.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : p1p2_arbiter_if.slave (requests/done in, grants/status out)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no grant; arbitrate on the next edge
// GNT1    | g1 high, hcnt counts grant cycles
// GNT2    | g2 high, hcnt counts grant cycles
// GAP     | dead time after a release, gcnt counts cycles
module p1p2_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int GAP      = 1
) (
  input logic           clk,
  input logic           reset,
  p1p2_arbiter_if.slave bus
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GNT1, ST_GNT2, ST_GAP} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [3:0]    gcnt, gcnt_nxt;
  logic          g1_q, g2_q, z_q, last_q, timeout_q;
  logic          g1_nxt, g2_nxt, z_nxt, last_nxt, timeout_nxt;

  logic pick1, pick2, hold_lim, rel1, rel2;

  // On a tie, the side that was not served last wins.
  assign pick1    = bus.P1 & (~bus.P2 | last_q);
  assign pick2    = bus.P2 & (~bus.P1 | ~last_q);
  assign hold_lim = (hcnt == HW'(HOLD_MAX));
  assign rel1     = bus.done1 | ~bus.P1 | hold_lim;
  assign rel2     = bus.done2 | ~bus.P2 | hold_lim;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hcnt      <= '0;
      gcnt      <= '0;
      g1_q      <= 1'b0;
      g2_q      <= 1'b0;
      z_q       <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      gcnt      <= gcnt_nxt;
      g1_q      <= g1_nxt;
      g2_q      <= g2_nxt;
      z_q       <= z_nxt;
      last_q    <= last_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick1)      state_nxt = ST_GNT1;
        else if (pick2) state_nxt = ST_GNT2;
      end
      ST_GNT1: if (rel1) state_nxt = ST_GAP;
      ST_GNT2: if (rel2) state_nxt = ST_GAP;
      ST_GAP:  if (gcnt == 4'(GAP - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so g1/g2/z change
  // on the same edge as the state transition.
  always_comb begin
    hcnt_nxt    = hcnt;
    gcnt_nxt    = gcnt;
    last_nxt    = last_q;
    timeout_nxt = 1'b0;
    g1_nxt      = (state_nxt == ST_GNT1);
    g2_nxt      = (state_nxt == ST_GNT2);
    z_nxt       = g1_nxt | g2_nxt;
    case (state)
      ST_IDLE: begin
        if (pick1) begin
          hcnt_nxt = HW'(1);
          last_nxt = 1'b0;
        end else if (pick2) begin
          hcnt_nxt = HW'(1);
          last_nxt = 1'b1;
        end
      end
      ST_GNT1: begin
        if (rel1) begin
          gcnt_nxt    = '0;
          // Timeout flags only a release caused by the hold limit alone.
          timeout_nxt = hold_lim & ~bus.done1 & bus.P1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      ST_GNT2: begin
        if (rel2) begin
          gcnt_nxt    = '0;
          timeout_nxt = hold_lim & ~bus.done2 & bus.P2;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      ST_GAP:  gcnt_nxt = gcnt + 1'b1;
      default: ;
    endcase
  end

  assign bus.g1      = g1_q;
  assign bus.g2      = g2_q;
  assign bus.z       = z_q;
  assign bus.last    = last_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_p1p2_arbiter.sv
// tb_p1p2_arbiter: directed bench for p1p2_arbiter with defaults
// HOLD_MAX=8, GAP=1. Inputs change #1 after a rising edge; outputs are
// sampled at that same point, away from the edge.
module tb_p1p2_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  p1p2_arbiter_if bus ();

  p1p2_arbiter #(.HOLD_MAX(8), .GAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.P1 = 1'b0; bus.P2 = 1'b0; bus.done1 = 1'b0; bus.done2 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // {g1, g2, z, timeout, last}
  function automatic logic [31:0] outs();
    return {27'd0, bus.g1, bus.g2, bus.z, bus.timeout, bus.last};
  endfunction

  initial begin
    int high, low, who, expect_who;
    bit got;

    // 1. reset and idle
    do_reset();
    check("reset_outs", outs(), 32'b00001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_outs", outs(), 32'b00001);
    end

    // 2. single request ended by done1 after 3 grant cycles
    bus.P1 = 1'b1;
    step();
    check("single_grant", outs(), 32'b10100);
    step();
    check("single_c2", outs(), 32'b10100);
    step();
    check("single_c3", outs(), 32'b10100);
    bus.done1 = 1'b1;
    step();
    check("single_release", outs(), 32'b00000);
    bus.done1 = 1'b0; bus.P1 = 1'b0;
    step();
    check("single_idle", outs(), 32'b00000);

    // 3. both requesting: alternate g1, g2, g1, g2 with 2 low cycles between
    do_reset();
    bus.P1 = 1'b1; bus.P2 = 1'b1;
    expect_who = 1;
    for (int k = 0; k < 4; k++) begin
      low = (k == 0) ? 0 : 1;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        step();
        check("rr_onehot", {31'd0, bus.g1 & bus.g2}, 32'd0);
        if (bus.g1 | bus.g2) got = 1'b1;
        else low++;
      end
      check("rr_grant_seen", {31'd0, got}, 32'd1);
      who = bus.g1 ? 1 : 2;
      check("rr_order", who, expect_who);
      if (k > 0) check("rr_gap_low", low, 2);
      check("rr_z", {31'd0, bus.z}, 32'd1);
      // done from the non-granted side must be ignored
      if (who == 1) bus.done2 = 1'b1; else bus.done1 = 1'b1;
      step();
      bus.done1 = 1'b0; bus.done2 = 1'b0;
      check("rr_hold_c2", {30'd0, bus.g1, bus.g2}, (who == 1) ? 32'b10 : 32'b01);
      if (who == 1) bus.done1 = 1'b1; else bus.done2 = 1'b1;
      step();
      bus.done1 = 1'b0; bus.done2 = 1'b0;
      check("rr_release", outs() & 32'b11110, 32'b00000);
      expect_who = (who == 1) ? 2 : 1;
    end

    // 4. hold timeout on P2
    do_reset();
    bus.P2 = 1'b1;
    step();
    check("to_grant", outs(), 32'b01101);
    high = 1;
    for (int t = 0; t < 20 && bus.g2; t++) begin
      step();
      if (bus.g2) begin
        high++;
        check("to_no_pulse", {31'd0, bus.timeout}, 32'd0);
      end
    end
    check("to_high_len", high, 8);
    check("to_pulse", outs(), 32'b00011);
    step();
    check("to_pulse_end", outs(), 32'b00001);
    step();
    check("to_regrant", outs(), 32'b01101);
    bus.P2 = 1'b0;
    step();

    // 5. done1 coincident with the hold limit
    do_reset();
    bus.P1 = 1'b1;
    step();
    for (int c = 2; c <= 8; c++) begin
      step();
      check("lim_hold", {31'd0, bus.g1}, 32'd1);
    end
    bus.done1 = 1'b1;
    step();
    check("lim_done_release", outs(), 32'b00000);
    bus.done1 = 1'b0; bus.P1 = 1'b0;
    step();

    // 6a. reset during the 3rd grant cycle
    do_reset();
    bus.P1 = 1'b1;
    step();
    step();
    step();
    check("rst_mid_before", {31'd0, bus.g1}, 32'd1);
    reset = 1'b1;
    step();
    check("rst_mid_after", outs(), 32'b00001);
    reset = 1'b0;
    bus.P1 = 1'b0;
    step();

    // 6b. P2 withdrawn during its grant
    bus.P2 = 1'b1;
    step();
    check("wd_grant", outs(), 32'b01101);
    step();
    bus.P2 = 1'b0;
    step();
    check("wd_release", outs(), 32'b00001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
